keypad_matrix_responder: RTL and testbench

//  Device-side model of the 4x4 membrane keypad: answers the column scan from keypad by driving row lines.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/bounce_lfsr.sv | 19 +
 rtl/keypad_matrix_responder.sv | 97 +++++++++
 tb/tb_keypad_matrix_responder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared 4x4 keypad geometry, key-code field layout and responder FSM encodings.
package keypad_pkg;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int IDX_W  = 2;
  // key code = {row index, column index}
  localparam int ROW_HI = 3;
  localparam int ROW_LO = 2;
  localparam int COL_HI = 1;
  localparam int COL_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_e;
endpackage

// File: rtl/bounce_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that supplies contact chatter.
module bounce_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic bit_o
);
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign bit_o  = lfsr_q[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     lfsr_q <= SEED;
    else if (en_i) lfsr_q <= lfsr_d;
  end
endmodule

// File: rtl/keypad_matrix_responder.sv
// Emulates a membrane keypad press (bounce in, hold, bounce out, gap) by pulling
// the addressed row low whenever its column is driven and the contact is closed.
module keypad_matrix_responder
  import keypad_pkg::*;
#(
  parameter logic [15:0] BOUNCE_CYCLES = 16'd64,
  parameter logic [15:0] HOLD_CYCLES   = 16'd4096,
  parameter logic [15:0] GAP_CYCLES    = 16'd1024,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] shift_col,
  output logic [3:0] row,
  input  logic [3:0] key_code,
  input  logic       press_req,
  output logic       busy,
  output logic       done,
  output logic       key_seen
);
  if (HOLD_CYCLES == 16'd0 || GAP_CYCLES == 16'd0) begin : g_bad_param
    $error("HOLD_CYCLES and GAP_CYCLES must be non-zero");
  end

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  code_q;
  logic        done_q, key_seen_q;
  logic        accept, last, bouncing, lfsr_bit, contact, col_driven;

  assign accept     = (state_q == ST_IDLE) && press_req;
  assign last       = (cnt_q <= 16'd1);
  assign bouncing   = (state_q == ST_BOUNCE_IN) || (state_q == ST_BOUNCE_OUT);
  assign contact    = (state_q == ST_HOLD) || (bouncing && lfsr_bit);
  assign col_driven = !shift_col[code_q[COL_HI:COL_LO]];

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en_i  (bouncing),
    .bit_o (lfsr_bit)
  );

  // Counter reloads on every transition and the state exits when it reaches 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (press_req) begin
        if (BOUNCE_CYCLES == 16'd0) begin state_d = ST_HOLD;      cnt_d = HOLD_CYCLES;   end
        else                        begin state_d = ST_BOUNCE_IN; cnt_d = BOUNCE_CYCLES; end
      end
      ST_BOUNCE_IN: if (last) begin state_d = ST_HOLD; cnt_d = HOLD_CYCLES; end
                    else cnt_d = cnt_q - 16'd1;
      ST_HOLD: if (last) begin
        if (BOUNCE_CYCLES == 16'd0) begin state_d = ST_GAP;        cnt_d = GAP_CYCLES;    end
        else                        begin state_d = ST_BOUNCE_OUT; cnt_d = BOUNCE_CYCLES; end
      end else cnt_d = cnt_q - 16'd1;
      ST_BOUNCE_OUT: if (last) begin state_d = ST_GAP; cnt_d = GAP_CYCLES; end
                     else cnt_d = cnt_q - 16'd1;
      ST_GAP: if (last) begin state_d = ST_IDLE; cnt_d = 16'd0; end
              else cnt_d = cnt_q - 16'd1;
      default: begin state_d = ST_IDLE; cnt_d = 16'd0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      code_q     <= 4'd0;
      done_q     <= 1'b0;
      key_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == ST_GAP) && last;
      if (accept) begin
        code_q     <= key_code;
        key_seen_q <= 1'b0;
      end else if ((state_q == ST_HOLD) && col_driven) begin
        key_seen_q <= 1'b1;
      end
    end
  end

  // Row sense behaves like a wire from the contact and the column drive.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      if (contact && (code_q[ROW_HI:ROW_LO] == r[IDX_W-1:0]) && col_driven) row[r] = 1'b0;
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign key_seen = key_seen_q;
endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Directed bench: two responders (BOUNCE=4 and BOUNCE=0, HOLD=20, GAP=5) checked cycle by cycle.
module tb_keypad_matrix_responder;
  localparam int H = 20;
  localparam int G = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] shift_col = 4'hF;
  logic [3:0] key_code = 4'h0;
  logic       press_a = 1'b0, press_b = 1'b0;
  logic [3:0] row_a, row_b;
  logic       busy_a, busy_b, done_a, done_b, ks_a, ks_b;
  logic [7:0] m_lfsr;
  int         n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  keypad_matrix_responder #(.BOUNCE_CYCLES(16'd4), .HOLD_CYCLES(16'd20), .GAP_CYCLES(16'd5),
    .LFSR_SEED(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .shift_col(shift_col), .row(row_a), .key_code(key_code),
    .press_req(press_a), .busy(busy_a), .done(done_a), .key_seen(ks_a));

  keypad_matrix_responder #(.BOUNCE_CYCLES(16'd0), .HOLD_CYCLES(16'd20), .GAP_CYCLES(16'd5),
    .LFSR_SEED(8'hA5)) dut_b (
    .clk(clk), .reset(reset), .shift_col(shift_col), .row(row_b), .key_code(key_code),
    .press_req(press_b), .busy(busy_b), .done(done_b), .key_seen(ks_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Returns the chatter contact bit and advances the reference LFSR.
  function automatic logic chatter();
    logic b;
    b      = m_lfsr[0];
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    return b;
  endfunction

  // Runs one press on dut_a (sel=0) or dut_b (sel=1); starts and ends just after a falling edge.
  task automatic run_press(input bit sel, input logic [3:0] code, input logic [3:0] col,
                           input logic [3:0] low_pat, input bit hold_req, input bit pulse,
                           input bit exp_ks, input string tag);
    int b, total, busy_n, low_n;
    logic c;
    logic [3:0] r;
    b = sel ? 0 : 4;
    total = 2 * b + H + G;
    busy_n = 0;
    low_n = 0;
    key_code = code;
    shift_col = col;
    if (sel) press_b = 1'b1; else press_a = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_req) begin press_a = 1'b0; press_b = 1'b0; end
    key_code = ~code;
    for (int k = 0; k <= total; k++) begin
      @(negedge clk);
      r = sel ? row_b : row_a;
      if ((sel ? busy_b : busy_a) === 1'b1) busy_n++;
      if (r !== 4'hF) low_n++;
      if (k == total) begin
        chk({tag, " done"}, sel ? done_b : done_a, 1);
        chk({tag, " busy_end"}, sel ? busy_b : busy_a, 0);
        chk({tag, " key_seen"}, sel ? ks_b : ks_a, exp_ks);
        chk({tag, " row_end"}, r, 4'hF);
      end else begin
        if (k < b)              c = chatter();
        else if (k < b + H)     c = 1'b1;
        else if (k < 2 * b + H) c = chatter();
        else                    c = 1'b0;
        chk({tag, " row"}, r, c ? low_pat : 4'hF);
        chk({tag, " done_mid"}, sel ? done_b : done_a, 0);
        if (pulse) press_a = (k % 7 == 3) && (k < total - 1);
      end
    end
    chk({tag, " busy_cycles"}, busy_n, total);
    if (sel) chk({tag, " low_cycles"}, low_n, H);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_lfsr = 8'hA5;
    @(negedge clk);
    chk("rst row", row_a, 4'hF);
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst key_seen", ks_a, 0);

    // Key 6 = row 1, col 2; column 2 driven.
    run_press(0, 4'h6, 4'b1011, 4'b1101, 0, 0, 1, "t1");
    @(negedge clk);
    chk("t1 done_after", done_a, 0);

    run_press(0, 4'h6, 4'b1101, 4'hF, 0, 0, 0, "t2_wrongcol");

    // Held request re-accepts in the done cycle; pulses during busy are ignored.
    run_press(0, 4'h6, 4'b1011, 4'b1101, 1, 0, 1, "t4_first");
    run_press(0, 4'h6, 4'b1011, 4'b1101, 0, 1, 1, "t4_second");
    press_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4 idle_busy", busy_a, 0);
      chk("t4 idle_done", done_a, 0);
    end

    // Reset at HOLD cycle 10.
    key_code = 4'h6;
    shift_col = 4'b1011;
    press_a = 1'b1;
    @(posedge clk);
    #1 press_a = 1'b0;
    for (int k = 0; k <= 14; k++) @(negedge clk);
    chk("t5 row_in_hold", row_a, 4'b1101);
    #2 reset = 1'b1;
    #1;
    chk("t5 row_async", row_a, 4'hF);
    chk("t5 busy_async", busy_a, 0);
    chk("t5 ks_async", ks_a, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5 no_done", done_a, 0);
      chk("t5 idle", busy_a, 0);
    end
    m_lfsr = 8'hA5;
    run_press(0, 4'h6, 4'b1011, 4'b1101, 0, 0, 1, "t5_after");

    run_press(1, 4'h6, 4'b1011, 4'b1101, 0, 0, 1, "t6_nobounce");
    // All columns driven at once: only the addressed row (row 3) is pulled.
    run_press(1, 4'hF, 4'b0000, 4'b0111, 0, 0, 1, "t7_allcols");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
